// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel record and clip-stage state encoding.
package vga_pkg;
    localparam logic [7:0] SCREEN_W = 8'd160;
    localparam logic [6:0] SCREEN_H = 7'd120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} clip_state_t;

    function automatic logic in_screen(input pixel_t p);
        return (p.x < SCREEN_W) && (p.y < SCREEN_H);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head output holds the last popped word while empty.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] last;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so full does not block a paired push.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pixel_clip_fifo.sv
// Clips engine pixels to the screen, buffers survivors, drains under out_ready.
// Optional PIXEL_DEDUP_EN drops a pixel identical to the previously pushed one.
module pixel_clip_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_x,
    input  logic [6:0]       in_y,
    input  logic [2:0]       in_colour,
    input  logic             in_plot,
    input  logic             in_done,
    input  logic             out_ready,
    output logic [7:0]       vga_x,
    output logic [6:0]       vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] plot_count,
    output logic [CNT_W-1:0] drop_count
);
    clip_state_t state;
    pixel_t      pix, head;
    logic        full, empty, pop, push, cand, active, dup, entry;

    assign pix      = '{x: in_x, y: in_y, colour: in_colour};
    assign active   = (state == STREAM) && in_plot;
    assign entry    = (state == IDLE) && start;
    assign cand     = active && in_screen(pix) && !dup;
    assign pop      = vga_plot && out_ready;
    assign push     = cand && (!full || pop);
    assign vga_plot = !empty;
    assign vga_x      = head.x;
    assign vga_y      = head.y;
    assign vga_colour = head.colour;

`ifdef PIXEL_DEDUP_EN
    pixel_t hist;
    logic   hist_vld;

    assign dup = hist_vld && (hist == pix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            hist_vld <= 1'b0;
        end else if (entry) begin
            hist_vld <= 1'b0;
        end else if (push) begin
            hist     <= pix;
            hist_vld <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    sync_fifo #(.WIDTH($bits(pixel_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (out_ready),
        .din   (pix),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE:   if (start) state <= STREAM;
                STREAM: if (in_done) state <= DRAIN;
                DRAIN:  if (empty) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE:   if (!start) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics restart with each stream and saturate instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plot_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (entry) begin
            plot_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop && plot_count != '1) plot_count <= plot_count + 1'b1;
            if (active && !push && drop_count != '1) drop_count <= drop_count + 1'b1;
            if (cand && !push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Bench for pixel_clip_fifo: clip table, overflow, full push/pop, dedup, done and reset sequences.
module tb_pixel_clip_fifo;
    import vga_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, start, in_plot, in_done, out_ready;
    logic [7:0]       in_x;
    logic [6:0]       in_y;
    logic [2:0]       in_colour;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             vga_plot, done, overflow;
    logic [CNT_W-1:0] plot_count, drop_count;

    pixel_clip_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_plot(in_plot), .in_done(in_done), .out_ready(out_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .done(done), .overflow(overflow),
        .plot_count(plot_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        bit exp_in;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    pixel_t sbq[$];
    pixel_t last_push;
    bit     last_vld;
    int     exp_drop, exp_plot;
    bit     exp_ovf;
    bit     mon_en = 1'b0;
    pixel_t mon_e;
    vec_t   tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: a pop happens at the next rising edge whenever plot and ready are both high.
    always @(negedge clk) begin
        if (mon_en && vga_plot === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got (%0d,%0d,%0d) expected none", vga_x, vga_y, vga_colour);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(mon_e));
                exp_plot++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int c);
        pixel_t p;
        bit     inb, dp, popn;
        p.x = 8'(x);
        p.y = 7'(y);
        p.colour = 3'(c);
        in_x = p.x;
        in_y = p.y;
        in_colour = p.colour;
        in_plot = 1'b1;
        inb = (x < 160) && (y < 120);
`ifdef PIXEL_DEDUP_EN
        dp = last_vld && (last_push == p);
`else
        dp = 1'b0;
`endif
        popn = (sbq.size() > 0) && out_ready;
        if (!inb || dp) exp_drop++;
        else if (sbq.size() < DEPTH || popn) begin
            sbq.push_back(p);
            last_push = p;
            last_vld = 1'b1;
        end else begin
            exp_drop++;
            exp_ovf = 1'b1;
        end
        step();
        in_plot = 1'b0;
    endtask

    task automatic begin_stream();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        exp_drop = 0;
        exp_plot = 0;
        exp_ovf = 1'b0;
        last_vld = 1'b0;
    endtask

    task automatic end_stream(input string name);
        int n;
        out_ready = 1'b1;
        in_done = 1'b1;
        step();
        in_done = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_plot_count"}, 32'(plot_count), 32'(exp_plot));
        chk({name, "_drop_count"}, 32'(drop_count), 32'(exp_drop));
        chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({name, "_left_in_queue"}, 32'(sbq.size()), 32'd0);
        start = 1'b0;
        step();
        chk({name, "_done_clear"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int drops;
        rst = 1'b1; start = 1'b0; in_plot = 1'b0; in_done = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_colour = '0;
        #12;
        chk("rst_vga_plot", 32'(vga_plot), 32'd0);
        chk("rst_vga_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_plot_count", 32'(plot_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        // Clip table including every edge of the screen rectangle.
        tbl[0] = '{160, 14, 1, 1'b0};
        tbl[1] = '{80, 94, 2, 1'b1};
        tbl[2] = '{0, 14, 3, 1'b1};
        tbl[3] = '{80, 120, 4, 1'b0};
        tbl[4] = '{159, 119, 5, 1'b1};
        tbl[5] = '{0, 0, 6, 1'b1};
        tbl[6] = '{255, 127, 7, 1'b0};
        tbl[7] = '{159, 120, 1, 1'b0};
        tbl[8] = '{160, 119, 2, 1'b0};
        tbl[9] = '{0, 119, 0, 1'b1};
        begin_stream();
        out_ready = 1'b1;
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].c);
            if (!tbl[i].exp_in) drops++;
            chk($sformatf("clip_vec%0d_drop_count", i), 32'(drop_count), 32'(drops));
        end
        end_stream("clip");

        // Backpressure: 20 pixels into 16 entries.
        begin_stream();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) drive(i + 10, i, i % 8);
        chk("ovf_vga_plot", 32'(vga_plot), 32'd1);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd4);
        end_stream("ovf");
        chk("ovf_total_plots", 32'(plot_count), 32'd16);

        // Full FIFO with a simultaneous push and pop.
        begin_stream();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive(i, 50, 1);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        drive(5, 5, 5);
        out_ready = 1'b0;
        chk("full_pp_overflow", 32'(overflow), 32'd0);
        chk("full_pp_drop_count", 32'(drop_count), 32'd0);
        drive(6, 6, 6);
        chk("full_still_full_overflow", 32'(overflow), 32'd1);
        chk("full_still_full_drop", 32'(drop_count), 32'd1);
        end_stream("full");
        chk("full_total_plots", 32'(plot_count), 32'd17);

        // Duplicate suppression.
        begin_stream();
        out_ready = 1'b1;
        drive(80, 94, 2);
        drive(80, 94, 2);
        drive(82, 94, 2);
`ifdef PIXEL_DEDUP_EN
        chk("dedup_drop_count", 32'(drop_count), 32'd1);
`else
        chk("dedup_drop_count", 32'(drop_count), 32'd0);
`endif
        end_stream("dedup");
`ifdef PIXEL_DEDUP_EN
        chk("dedup_plots", 32'(plot_count), 32'd2);
`else
        chk("dedup_plots", 32'(plot_count), 32'd3);
`endif

        // Done sequencing under backpressure.
        begin_stream();
        out_ready = 1'b0;
        drive(1, 1, 1);
        drive(2, 2, 2);
        drive(3, 3, 3);
        in_done = 1'b1;
        step();
        in_done = 1'b0;
        start = 1'b0;
        repeat (3) step();
        chk("seq_done_held", 32'(done), 32'd0);
        chk("seq_vga_plot_held", 32'(vga_plot), 32'd1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("seq_done_at_last_pop", 32'(done), 32'd0);
        chk("seq_empty_after_pops", 32'(vga_plot), 32'd0);
        chk("seq_hold_last_x", 32'(vga_x), 32'd3);
        step();
        chk("seq_done_rise", 32'(done), 32'd1);
        chk("seq_plot_count", 32'(plot_count), 32'd3);
        step();
        chk("seq_done_fall", 32'(done), 32'd0);

        // Reset in the middle of a stream.
        begin_stream();
        out_ready = 1'b0;
        drive(200, 5, 1);
        for (int i = 0; i < 8; i++) drive(20 + i, 30, 4);
        chk("rstmid_pre_drop", 32'(drop_count), 32'd1);
        chk("rstmid_pre_plot", 32'(vga_plot), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_vga_plot", 32'(vga_plot), 32'd0);
        chk("rstmid_vga_x", 32'(vga_x), 32'd0);
        chk("rstmid_plot_count", 32'(plot_count), 32'd0);
        chk("rstmid_drop_count", 32'(drop_count), 32'd0);
        chk("rstmid_overflow", 32'(overflow), 32'd0);
        sbq.delete();
        start = 1'b0;
        #3;
        rst = 1'b0;
        step();
        in_x = 8'd10; in_y = 7'd10; in_colour = 3'd1; in_plot = 1'b1;
        repeat (2) step();
        in_plot = 1'b0;
        chk("rstmid_idle_no_push", 32'(vga_plot), 32'd0);
        chk("rstmid_idle_no_drop", 32'(drop_count), 32'd0);
        chk("rstmid_idle_done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
